// File: rtl/dp_mem_pkg.sv
// Shared defaults and word/pointer/count types for the dp_mem FIFO controller.
package dp_mem_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;
    typedef logic [DEF_ADDR_W:0]   cnt_t;

endpackage

// File: rtl/dp_mem_fifo_ctrl_if.sv
// Bundle of the FIFO push/pop side and the dp_mem port side of the controller.
interface dp_mem_fifo_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              mem_enb;
    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_w_data;
    logic [DATA_W-1:0] mem_r_data;

    // The controller sits on the slave side; source/sink and memory model on the master side.
    modport slave (
        input  push, push_data, pop, mem_r_data,
        output pop_data, pop_valid, full, empty, almost_full, count,
               overflow, underflow, mem_enb, mem_wr, mem_rd,
               mem_w_addr, mem_r_addr, mem_w_data
    );

    modport master (
        output push, push_data, pop, mem_r_data,
        input  pop_data, pop_valid, full, empty, almost_full, count,
               overflow, underflow, mem_enb, mem_wr, mem_rd,
               mem_w_addr, mem_r_addr, mem_w_data
    );
endinterface

// File: rtl/dp_mem_fifo_ptr.sv
// Wrapping ADDR_W-bit pointer; rolls over DEPTH-1 -> 0 by natural overflow.
module dp_mem_fifo_ptr
    import dp_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/dp_mem_fifo_ctrl.sv
// Push/pop FIFO controller driving a dual-port memory with 1-cycle registered reads.
module dp_mem_fifo_ctrl
    import dp_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int AFULL_TH = 12
) (
    input  logic              clk,
    input  logic              rst,
    dp_mem_fifo_ctrl_if.slave bus
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AFULL_C = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic              push_acc;
    logic              pop_acc;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic [ADDR_W:0]   count_q,       count_d;
    logic              full_q,        full_d;
    logic              empty_q,       empty_d;
    logic              almost_full_q, almost_full_d;
    logic              overflow_q,    overflow_d;
    logic              underflow_q,   underflow_d;
    logic              pop_valid_q,   pop_valid_d;

    // Accept decisions use only registered flags, so a push never bypasses into an empty pop.
    always_comb begin
        push_acc      = bus.push & ~full_q;
        pop_acc       = bus.pop  & ~empty_q;

        count_d       = count_q;
        if (push_acc && !pop_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - CNT_ONE;
        end

        full_d        = (count_d == DEPTH_C);
        empty_d       = (count_d == '0);
        almost_full_d = (count_d >= AFULL_C);

        overflow_d    = overflow_q  | (bus.push & full_q);
        underflow_d   = underflow_q | (bus.pop  & empty_q);
        pop_valid_d   = pop_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            pop_valid_q   <= 1'b0;
        end else begin
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            pop_valid_q   <= pop_valid_d;
        end
    end

    dp_mem_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_acc),
        .ptr (wr_ptr)
    );

    dp_mem_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_acc),
        .ptr (rd_ptr)
    );

    // Memory port is driven combinationally so the write/read lands in the accept cycle.
    assign bus.mem_wr      = push_acc;
    assign bus.mem_rd      = pop_acc;
    assign bus.mem_enb     = push_acc | pop_acc;
    assign bus.mem_w_addr  = wr_ptr;
    assign bus.mem_r_addr  = rd_ptr;
    assign bus.mem_w_data  = bus.push_data;

    assign bus.pop_data    = bus.mem_r_data;
    assign bus.pop_valid   = pop_valid_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.almost_full = almost_full_q;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_dp_mem_fifo_ctrl.sv
// Scoreboard bench: the stimulus side queues expected pop data, a monitor checks each pop_valid.
module tb_dp_mem_fifo_ctrl;
    import dp_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dp_mem_fifo_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    dp_mem_fifo_ctrl #(.ADDR_W(4), .DATA_W(8), .AFULL_TH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural dp_mem: registered read data one cycle after rd.
    data_t mem [16];
    always @(posedge clk) begin
        if (bus.mem_enb && bus.mem_wr) mem[bus.mem_w_addr] <= bus.mem_w_data;
        if (bus.mem_enb && bus.mem_rd) bus.mem_r_data <= mem[bus.mem_r_addr];
    end

    int    total = 0;
    int    bad   = 0;
    data_t ref_q[$];
    data_t exp_q[$];
    int    m_cnt = 0;

    logic  s_wr, s_rd, s_enb;
    addr_t s_waddr, s_raddr;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.pop_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_valid_unexpected: got pop_valid=1 data=%0h expected no pop_valid", bus.pop_data);
            end else begin
                data_t e;
                e = exp_q.pop_front();
                if (bus.pop_data !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %0h expected %0h", bus.pop_data, e);
                end
            end
        end
    end

    // One clock of stimulus; the reference decides acceptance from its own occupancy.
    task automatic cyc(input logic pu, input data_t pd, input logic po);
        logic pa, qa;
        @(negedge clk);
        bus.push = pu; bus.push_data = pd; bus.pop = po;
        #1;
        s_wr = bus.mem_wr; s_rd = bus.mem_rd; s_enb = bus.mem_enb;
        s_waddr = bus.mem_w_addr; s_raddr = bus.mem_r_addr;
        @(posedge clk);
        pa = pu && (m_cnt < 16);
        qa = po && (m_cnt > 0);
        if (qa) exp_q.push_back(ref_q.pop_front());
        if (pa) ref_q.push_back(pd);
        m_cnt = m_cnt + (pa ? 1 : 0) - (qa ? 1 : 0);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, int'(bus.count), 0);
        chk({tag, "_empty"}, int'(bus.empty), 1);
        chk({tag, "_full"}, int'(bus.full), 0);
        chk({tag, "_afull"}, int'(bus.almost_full), 0);
        chk({tag, "_pop_valid"}, int'(bus.pop_valid), 0);
        chk({tag, "_overflow"}, int'(bus.overflow), 0);
        chk({tag, "_underflow"}, int'(bus.underflow), 0);
        chk({tag, "_mem_enb"}, int'(bus.mem_enb), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst0");
        @(negedge clk);
        rst = 1'b0;

        // Three pushes then three pops
        cyc(1'b1, 8'h11, 1'b0); chk("t1_wr0", int'(s_wr), 1); chk("t1_waddr0", int'(s_waddr), 0);
        cyc(1'b1, 8'h22, 1'b0); chk("t1_waddr1", int'(s_waddr), 1);
        cyc(1'b1, 8'h33, 1'b0); chk("t1_waddr2", int'(s_waddr), 2);
        chk("t1_count3", int'(bus.count), 3);
        chk("t1_empty0", int'(bus.empty), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("t1_rd", int'(s_rd), 1);
        end
        chk("t1_empty1", int'(bus.empty), 1);
        cyc(1'b0, 8'h00, 1'b0);

        // Fill to full, almost_full threshold, then overflow
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, data_t'(i), 1'b0);
            chk("t2_afull", int'(bus.almost_full), (i + 1 >= 12) ? 1 : 0);
            chk("t2_full", int'(bus.full), (i == 15) ? 1 : 0);
        end
        chk("t2_count16", int'(bus.count), 16);
        chk("t2_ovf_before", int'(bus.overflow), 0);
        cyc(1'b1, 8'h10, 1'b0);
        chk("t2_wr_rejected", int'(s_wr), 0);
        chk("t2_overflow", int'(bus.overflow), 1);
        chk("t2_count_hold", int'(bus.count), 16);

        // Drain, then underflow and empty push+pop
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("t3_empty", int'(bus.empty), 1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t3_rd_rejected", int'(s_rd), 0);
        chk("t3_underflow", int'(bus.underflow), 1);
        chk("t3_no_pop_valid", int'(bus.pop_valid), 0);
        cyc(1'b1, 8'hA5, 1'b1);
        chk("t3_pp_wr", int'(s_wr), 1);
        chk("t3_pp_rd", int'(s_rd), 0);
        chk("t3_pp_count", int'(bus.count), 1);
        chk("t3_pp_no_pop_valid", int'(bus.pop_valid), 0);

        // Steady state at count 5: 20 push+pop cycles wrap both pointers
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hB0 + data_t'(i), 1'b0);
        chk("t4_count5", int'(bus.count), 5);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'hC0 + data_t'(i), 1'b1);
        chk("t4_waddr_last", int'(s_waddr), 11);
        chk("t4_raddr_last", int'(s_raddr), 6);
        chk("t4_count_hold", int'(bus.count), 5);

        // Reach count 7 with a pop in flight, then reset asynchronously
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hD0 + data_t'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t6_count7", int'(bus.count), 7);
        chk("t6_pv_pending", int'(bus.pop_valid), 1);
        @(negedge clk);
        bus.pop = 1'b1;
        #1;
        chk("t6_rd_issued", int'(bus.mem_rd), 1);
        rst = 1'b1;
        #1;
        chk_reset_state("t6_async");
        ref_q.delete();
        m_cnt = 0;
        bus.pop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        chk("t6_no_pv_after", int'(bus.pop_valid), 0);
        cyc(1'b1, 8'h5A, 1'b0);
        chk("t6_waddr0", int'(s_waddr), 0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t6_raddr0", int'(s_raddr), 0);
        cyc(1'b0, 8'h00, 1'b0);

        // Full with push+pop: pop wins, push rejected
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'hE0 + data_t'(i), 1'b0);
        chk("t5_full", int'(bus.full), 1);
        chk("t5_ovf_before", int'(bus.overflow), 0);
        cyc(1'b1, 8'hEE, 1'b1);
        chk("t5_rd", int'(s_rd), 1);
        chk("t5_wr_rejected", int'(s_wr), 0);
        chk("t5_overflow", int'(bus.overflow), 1);
        chk("t5_count15", int'(bus.count), 15);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("end_scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dp_mem_fifo_ctrl.md
Name: dp_mem_fifo_ctrl

Overview:
- Upstream controller that turns a push/pop FIFO interface into dp_mem port traffic: enb, wr, rd, w_addr, r_addr, w_data.
- Owns the write and read pointers, occupancy count and full/empty flags.
- Aligns dp_mem's 1-cycle registered read data with a pop_valid strobe.
- Sits between the packet source/sink and dp_mem, making dp_mem a synchronous FIFO.

Parameters:
- ADDR_W, 4, dp_mem address width; DEPTH = 2**ADDR_W entries.
- DATA_W, 8, data word width.
- AFULL_TH, 12, count at or above which almost_full asserts (1..DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  write request.
- push_data  in  DATA_W  word to store.
- pop  in  1  read request.
- pop_data  out  DATA_W  read word; equals mem_r_data.
- pop_valid  out  1  pop_data valid this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- count  out  ADDR_W+1  current occupancy.
- overflow  out  1  sticky: push while full.
- underflow  out  1  sticky: pop while empty.
- mem_enb  out  1  to dp_mem enb.
- mem_wr  out  1  to dp_mem wr.
- mem_rd  out  1  to dp_mem rd.
- mem_w_addr  out  ADDR_W  to dp_mem w_addr.
- mem_r_addr  out  ADDR_W  to dp_mem r_addr.
- mem_w_data  out  DATA_W  to dp_mem w_data.
- mem_r_data  in  DATA_W  from dp_mem read port; valid 1 cycle after rd.

Behaviour:
- Reset (async assert, sync deassert use): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, pop_valid=0, overflow=0, underflow=0. A pending read return is discarded; pop_valid stays 0 the cycle after reset releases.
- Accept rules:
  - push_acc = push & !full.
  - pop_acc = pop & !empty.
  - Both use the registered flags, with no same-cycle fall-through or bypass.
- Simultaneous events:
  - Empty with push & pop: push accepted, pop rejected, underflow set.
  - Full with push & pop: pop accepted, push rejected, overflow set.
  - Otherwise both accepted and count is unchanged.
- Memory drive (combinational from accept and pointers):
  - mem_wr = push_acc, mem_rd = pop_acc, mem_enb = push_acc | pop_acc.
  - mem_w_addr = wr_ptr, mem_r_addr = rd_ptr, mem_w_data = push_data.
- Pointers increment on their accept and wrap DEPTH-1 -> 0 by natural ADDR_W overflow.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Range is 0..DEPTH, never wraps.
- Flags are registered, derived from next-state count, and valid in the cycle after the update.
- Read latency:
  - pop_valid = registered pop_acc, 1 cycle after the pop handshake.
  - pop_data = mem_r_data, unregistered pass-through.
- overflow/underflow set on the rejected request, held until rst.
- Same-address write and read never happen: only possible when count==0 (pop rejected) or count==DEPTH (push rejected).

Decomposition:
- Package dp_mem_pkg holds:
  - default ADDR_W and DATA_W localparams;
  - typedefs addr_t = logic[ADDR_W-1:0], data_t = logic[DATA_W-1:0], cnt_t = logic[ADDR_W:0].
- One sub-module, dp_mem_fifo_ptr: an ADDR_W-bit wrapping counter with clk, rst and inc, output ptr. It is instantiated twice, once for the write pointer and once for the read pointer.

Test Plan:
- Reset then push 0x11,0x22,0x33 on consecutive cycles -> mem_w_addr 0,1,2, count=3, empty=0; then pop x3 -> pop_valid on the cycles after each pop, pop_data 0x11,0x22,0x33, empty=1.
- Push 16 words 0x00..0x0F -> full=1, count=16, almost_full from count 12. A 17th push -> mem_wr=0, overflow=1, count stays 16.
- From empty, pop -> mem_rd=0, underflow=1, pop_valid stays 0. Same cycle push+pop -> only the push is accepted, count=1.
- At count=5, push+pop for 20 cycles -> count stays 5 and both pointers wrap past 15 to 0. Data order is preserved, checked against a reference queue.
- Full with push+pop -> the pop returns the oldest word, the push is rejected with overflow=1, count=15.
- Assert rst mid-stream with count=7 and a pop just issued -> all outputs return to reset values asynchronously. No pop_valid after release; the next push lands at address 0.
